// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one LFSR PRNG among N_REQ requesters; seeds it lazily from a
// free-running counter. Define PRNG_ARB_BURST_EN to allow up to MAX_BURST draws per grant.
module prng_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned SEED_W    = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_REQ-1:0]  i_req,
  input  logic              i_reseed,
  output logic [N_REQ-1:0]  o_gnt,
  output logic [N_REQ-1:0]  o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_set_seed,
  output logic [SEED_W-1:0] o_seed,
  input  logic [DATA_W-1:0] i_random_num,
  output logic              o_generate
);

`ifdef PRNG_ARB_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  localparam int unsigned IdxW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [IdxW:0]     NReqW    = (IdxW + 1)'(N_REQ);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST - 1);

  typedef enum logic [1:0] {StIdle, StSeed, StGen, StResp} state_e;

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     winner_q, winner_d;
  logic [BurstW-1:0]   burst_cnt_q, burst_cnt_d;
  logic                seeded_q, seeded_d;
  logic [SEED_W-1:0]   counter_q;

  logic [N_REQ-1:0]    req_rot;
  logic [IdxW-1:0]     rot_off;
  logic [IdxW:0]       rot_sum, rot_wrap;
  logic [IdxW-1:0]     pick_idx;
  logic [IdxW:0]       ptr_sum;
  logic [IdxW-1:0]     ptr_inc;
  logic                burst_go;

  // Rotate requests so bit 0 is rr_ptr; first set bit gives the cyclic offset of the winner.
  always_comb begin
    req_rot = N_REQ'({i_req, i_req} >> rr_ptr_q);
    rot_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rot_off = IdxW'(k);
      end
    end
    rot_sum  = {1'b0, rr_ptr_q} + {1'b0, rot_off};
    rot_wrap = rot_sum - NReqW;
    pick_idx = (rot_sum >= NReqW) ? rot_wrap[IdxW-1:0] : rot_sum[IdxW-1:0];
  end

  always_comb begin
    ptr_sum = {1'b0, winner_q} + 1'b1;
    ptr_inc = (ptr_sum == NReqW) ? '0 : ptr_sum[IdxW-1:0];
  end

  assign burst_go = BurstEn && i_req[winner_q] && (burst_cnt_q < BurstMax);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          state_d = seeded_q ? StGen : StSeed;
        end
      end
      StSeed:  state_d = StGen;
      StGen:   state_d = StResp;
      StResp:  state_d = burst_go ? StGen : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy     = (state_q != StIdle);
    o_set_seed = (state_q == StSeed);
    o_generate = (state_q == StGen);
  end

  always_comb begin
    gnt_d       = gnt_q;
    valid_d     = '0;
    data_d      = data_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    burst_cnt_d = burst_cnt_q;
    seeded_d    = seeded_q;
    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          gnt_d    = {{(N_REQ - 1){1'b0}}, 1'b1} << pick_idx;
          winner_d = pick_idx;
        end
      end
      StSeed: seeded_d = 1'b1;
      StGen: ;
      StResp: begin
        data_d  = i_random_num;
        valid_d = gnt_q;
        if (burst_go) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          gnt_d       = '0;
          rr_ptr_d    = ptr_inc;
          burst_cnt_d = '0;
        end
      end
      default: ;
    endcase
    // A reseed landing during the seed cycle still wins, forcing another seed next draw.
    if (i_reseed) begin
      seeded_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      gnt_q       <= '0;
      valid_q     <= '0;
      data_q      <= '0;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      burst_cnt_q <= '0;
      seeded_q    <= 1'b0;
      counter_q   <= '0;
    end else begin
      gnt_q       <= gnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      burst_cnt_q <= burst_cnt_d;
      seeded_q    <= seeded_d;
      counter_q   <= counter_q + 1'b1;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_seed  = counter_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: a stand-in 4-bit LFSR, a draw-schedule model checked every cycle,
// and directed scenarios with literal expectations.
module tb_prng_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
`ifdef PRNG_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, reseed;
  logic [3:0]  req, gnt, valid, data, rnd;
  logic        busy, set_seed, gen;
  logic [15:0] seed;

  always #5 clk = ~clk;

  prng_arbiter #(.N_REQ(N), .DATA_W(4), .SEED_W(16), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_reseed(reseed), .o_gnt(gnt),
    .o_valid(valid), .o_data(data), .o_busy(busy), .o_set_seed(set_seed), .o_seed(seed),
    .i_random_num(rnd), .o_generate(gen)
  );

  function automatic logic [3:0] lstep(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction
  function automatic logic [3:0] lseed(input logic [15:0] s);
    return (s[3:0] == 4'h0) ? 4'h1 : s[3:0];
  endfunction

  // External PRNG stand-in driven by the DUT's controls
  logic [3:0] lfsr = 4'h1;
  always @(posedge clk) begin
    if (set_seed) lfsr <= lseed(seed);
    else if (gen) lfsr <= lstep(lfsr);
  end
  assign rnd = lfsr;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each draw is a schedule of absolute cycle numbers for seed/generate/response.
  int          cyc = 0;
  bit          m_live = 0;
  int          m_owner = -1, m_seed_at = -1, m_gen_at = -1, m_resp_at = -1;
  int          m_burst = 0, m_rr = 0;
  bit          m_seeded = 0;
  logic [15:0] m_cnt = '0;
  logic [3:0]  m_lfsr = 4'h1, m_data = '0, m_valid = '0;

  task automatic model_step();
    if (cyc == m_seed_at) m_lfsr = lseed(m_cnt);
    else if (cyc == m_gen_at) m_lfsr = lstep(m_lfsr);
    if (!rst_n) begin
      m_live = 1; m_owner = -1; m_seed_at = -1; m_gen_at = -1; m_resp_at = -1;
      m_burst = 0; m_rr = 0; m_seeded = 0; m_cnt = '0; m_data = '0; m_valid = '0;
    end else if (m_live) begin
      m_valid = '0;
      if (cyc == m_seed_at) m_seeded = 1;
      if (m_owner >= 0 && cyc == m_resp_at) begin
        m_data  = m_lfsr;
        m_valid = 4'(1 << m_owner);
        if (BURST && req[m_owner] && m_burst < MB - 1) begin
          m_burst++; m_gen_at = cyc + 1; m_resp_at = cyc + 2;
        end else begin
          m_rr = (m_owner + 1) % N; m_owner = -1; m_burst = 0;
        end
      end else if (m_owner < 0 && req != 4'b0) begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && req[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
        if (m_seeded) begin
          m_gen_at = cyc + 1; m_resp_at = cyc + 2;
        end else begin
          m_seed_at = cyc + 1; m_gen_at = cyc + 2; m_resp_at = cyc + 3;
        end
      end
      if (reseed) m_seeded = 0;
      m_cnt++;
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("m_gnt", gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("m_busy", busy, (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("m_set_seed", set_seed, (cyc == m_seed_at) ? 32'd1 : 32'd0);
      chk("m_generate", gen, (cyc == m_gen_at) ? 32'd1 : 32'd0);
      chk("m_valid", valid, m_valid);
      chk("m_data", data, m_data);
      chk("m_seed", seed, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (valid == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    if (valid == 4'b0) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_valid: got no o_valid within 20 cycles, required a pulse");
    end
  endtask

  initial begin
    logic [3:0] exp_data [5];
    logic [3:0] exp_vld  [5];
    exp_data = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6};
    exp_vld  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0; req = '0; reseed = 1'b0;
    tick(); tick();
    chk("rst_gnt", gnt, 0); chk("rst_valid", valid, 0);
    chk("rst_data", data, 0); chk("rst_busy", busy, 0);
`ifdef PRNG_ARB_BURST_EN
    rst_n = 1'b1; req = 4'b0001;
    tick(); tick(); tick(); tick();
    chk("b_valid0", valid, 4'b0001); chk("b_gnt_kept", gnt, 4'b0001);
    for (int k = 1; k < 4; k++) begin
      tick(); chk("b_gap", valid, 0);
      tick(); chk("b_valid", valid, 4'b0001);
    end
    chk("b_release", gnt, 0);
    req = '0;
    repeat (5) tick();
`else
    // First draw after reset seeds with counter=1, PRNG 1 -> 2
    rst_n = 1'b1; req = 4'b0001;
    tick();
    chk("t1_set_seed", set_seed, 1); chk("t1_seed", seed, 16'd1); chk("t1_gnt", gnt, 4'b0001);
    req = '0;
    tick(); chk("t1_generate", gen, 1);
    tick(); tick();
    chk("t1_valid", valid, 4'b0001); chk("t1_data", data, 4'h2); chk("t1_gnt_off", gnt, 0);
    tick(); chk("t1_pulse", valid, 0); chk("t1_hold", data, 4'h2);

    // All requesting: round robin every 3 cycles after the seeded first draw
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 4'b1111;
    tick(); tick(); tick(); tick();
    chk("rr_valid0", valid, exp_vld[0]); chk("rr_data0", data, exp_data[0]);
    for (int k = 1; k < 5; k++) begin
      tick(); tick(); tick();
      chk("rr_valid", valid, exp_vld[k]); chk("rr_data", data, exp_data[k]);
    end
    req = '0;
    tick();

    // Move rr_ptr to 2, then 0 must beat 1
    req = 4'b0010;
    tick(); req = '0;
    wait_valid(); chk("p2_valid", valid, 4'b0010);
    req = 4'b0011;
    tick(); chk("wrap_gnt0", gnt, 4'b0001);
    wait_valid(); chk("wrap_valid0", valid, 4'b0001);
    tick(); chk("wrap_gnt1", gnt, 4'b0010);
    req = '0;
    wait_valid(); chk("wrap_valid1", valid, 4'b0010);

    // Reseed between draws
    tick(); reseed = 1'b1;
    tick(); reseed = 1'b0; req = 4'b0100;
    tick(); chk("rs_set_seed", set_seed, 1); chk("rs_gnt", gnt, 4'b0100);
    req = '0;
    wait_valid(); chk("rs_valid", valid, 4'b0100);

    // Reset while generating aborts the draw
    tick(); req = 4'b1000;
    tick(); chk("ab_generate", gen, 1);
    rst_n = 1'b0; req = '0;
    tick(); chk("ab_gnt", gnt, 0); chk("ab_busy", busy, 0); chk("ab_valid", valid, 0);
    rst_n = 1'b1;
    tick(); chk("ab_no_valid", valid, 0);
    tick(); req = 4'b0001;
    tick(); chk("ab_reseed", set_seed, 1);
    req = '0;
    wait_valid(); chk("ab_valid_after", valid, 4'b0001);
    repeat (3) tick();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
